// File: rtl/lsu_dmem_master_pkg.sv
// Shared definitions for the load/store unit data-memory master:
// funct3 encodings, FSM state encoding, access-size decode and alignment helpers.
package lsu_dmem_master_pkg;

    localparam int XLEN = 32;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Decode access width; unused load encodings act as LW, store funct3[1:0]==11 as SW.
    function automatic lsu_size_e access_size(input logic store, input logic [2:0] funct3);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (store) begin
            if (funct3[1:0] == F3_SB[1:0])      sz = SZ_BYTE;
            else if (funct3[1:0] == F3_SH[1:0]) sz = SZ_HALF;
            else                                sz = SZ_WORD;
        end else begin
            case (funct3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    // Byte accesses are never misaligned; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] addr_lo);
        logic bad;
        case (sz)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // LB/LH sign-extend; LBU/LHU zero-extend (funct3[2] set).
    function automatic logic load_is_signed(input logic [2:0] funct3);
        return !funct3[2];
    endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Request/response and data-memory signals of the LSU grouped into one bundle.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// the requester holds fields stable while req_valid is high and req_ready is low.
// resp_valid is a single-cycle pulse with no back-pressure.
interface lsu_dmem_master_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_data_in;
    logic [XLEN-1:0] dmem_data_out;
    logic            dmem_wen;
    logic            dmem_ren;

    // LSU side
    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, dmem_data_out,
        output req_ready, resp_valid, resp_data, resp_err,
        output dmem_addr, dmem_data_in, dmem_wen, dmem_ren
    );

    // Execute stage + memory side
    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, dmem_data_out,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  dmem_addr, dmem_data_in, dmem_wen, dmem_ren
    );
endinterface

// File: rtl/lsu_dmem_master_align.sv
// Combinational lane logic: extracts and extends the addressed byte/half of a read
// word for loads, and merges store data into the addressed lane for read-modify-write.
// The low address bits that would make an access misaligned are simply not looked at,
// so a misaligned half or word is treated as the aligned access containing it.
module lsu_dmem_master_align
    import lsu_dmem_master_pkg::*;
(
    input  lsu_size_e         size,
    input  logic              load_signed,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   rdata,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Load path: pick the lane, then sign- or zero-extend by access size
    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{load_signed & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{load_signed & lane_h[15]}}, lane_h};
            default: load_data = rdata;
        endcase
    end

    // Store path: overwrite only the addressed lane of the word just read
    always_comb begin
        merged = rdata;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged[7:0] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit, initiator side of a word-wide data memory without byte enables.
// Loads and SW take one memory cycle; SB/SH read the word, merge, and write it back.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned LH/LHU/LW/SH/SW
// complete one cycle after acceptance with resp_err=1 and no memory access; when not
// defined resp_err is tied low and offending low address bits are ignored.
module lsu_dmem_master
    import lsu_dmem_master_pkg::*;
#(
    parameter bit STORE_ACK = 1'b1
)(
    input  logic               clk,
    input  logic               rst,
    lsu_dmem_master_if.master  bus,
    output lsu_state_e         dbg_state
);

    lsu_state_e      state;
    lsu_size_e       size_q;
    logic            signed_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic            resp_valid_q;
    logic [XLEN-1:0] resp_data_q;
    logic            resp_err_q;

    logic            wen_q;
    logic            ren_q;
    logic [XLEN-1:0] dmem_addr_q;
    logic [XLEN-1:0] dmem_data_in_q;

    lsu_size_e       req_size;
    logic [XLEN-1:0] req_word_addr;
    logic            trap_hit;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;

    assign req_size      = access_size(bus.req_store, bus.req_funct3);
    assign req_word_addr = {bus.req_addr[XLEN-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_hit = misaligned(req_size, bus.req_addr[1:0]);
`else
    assign trap_hit = 1'b0;
`endif

    lsu_dmem_master_align u_align (
        .size        (size_q),
        .load_signed (signed_q),
        .addr_lo     (addr_q[1:0]),
        .rdata       (bus.dmem_data_out),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Request latch, FSM, registered strobes/address and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            size_q         <= SZ_WORD;
            signed_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            wen_q          <= 1'b0;
            ren_q          <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_data_in_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        size_q   <= req_size;
                        signed_q <= load_is_signed(bus.req_funct3);
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        if (trap_hit) begin
                            // Misaligned: report immediately, never touch memory
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else if (!bus.req_store) begin
                            state       <= ST_LOAD;
                            ren_q       <= 1'b1;
                            dmem_addr_q <= req_word_addr;
                        end else if (req_size == SZ_WORD) begin
                            state          <= ST_STORE;
                            wen_q          <= 1'b1;
                            dmem_addr_q    <= req_word_addr;
                            dmem_data_in_q <= bus.req_wdata;
                        end else begin
                            state       <= ST_RMW_RD;
                            ren_q       <= 1'b1;
                            dmem_addr_q <= req_word_addr;
                        end
                    end
                end
                ST_LOAD: begin
                    state        <= ST_IDLE;
                    ren_q        <= 1'b0;
                    dmem_addr_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= load_data;
                end
                ST_STORE: begin
                    state          <= ST_IDLE;
                    wen_q          <= 1'b0;
                    dmem_addr_q    <= '0;
                    dmem_data_in_q <= '0;
                    resp_valid_q   <= STORE_ACK;
                    resp_data_q    <= '0;
                end
                ST_RMW_RD: begin
                    // Address stays put; swap the read strobe for the write strobe
                    state          <= ST_RMW_WR;
                    ren_q          <= 1'b0;
                    wen_q          <= 1'b1;
                    dmem_data_in_q <= merged;
                end
                ST_RMW_WR: begin
                    state          <= ST_IDLE;
                    wen_q          <= 1'b0;
                    dmem_addr_q    <= '0;
                    dmem_data_in_q <= '0;
                    resp_valid_q   <= STORE_ACK;
                    resp_data_q    <= '0;
                end
                default: begin
                    state       <= ST_IDLE;
                    wen_q       <= 1'b0;
                    ren_q       <= 1'b0;
                    dmem_addr_q <= '0;
                end
            endcase
        end
    end

    // Strobes are masked during reset so an aborted RMW can never write
    assign bus.dmem_wen     = wen_q & ~rst;
    assign bus.dmem_ren     = ren_q & ~rst;
    assign bus.dmem_addr    = dmem_addr_q;
    assign bus.dmem_data_in = dmem_data_in_q;

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
    assign dbg_state      = state;

endmodule
